// File: rtl/bus_master_arbiter.sv
// Round-robin arbiter and transfer sequencer for the dValid/dAck/data bus.
// One requester at a time owns the bus for a 2..MAX_VALID cycle dValid burst.
module bus_master_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_VALID = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic                      timeout,
    output logic                      proto_err,
    output logic                      busy,
    output logic                      dValid,
    output logic [DATA_W-1:0]         data,
    input  logic                      dAck
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_VALID);
    localparam logic [PTR_W:0]   NUM_REQ_W = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_REQ  = PTR_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MAX_VALID - 1);

    typedef enum logic {
        S_IDLE,
        S_XFER
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                timeout_q, timeout_d;
    logic                perr_q, perr_d;

    logic                arb_found;
    logic [PTR_W-1:0]    arb_idx;
    logic [PTR_W-1:0]    arb_cand;
    logic [PTR_W:0]      arb_sum;
    logic [DATA_W-1:0]   sel_data;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_cand  = '0;
        arb_sum   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            arb_sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (arb_sum >= NUM_REQ_W) begin
                arb_sum = arb_sum - NUM_REQ_W;
            end
            arb_cand = arb_sum[PTR_W-1:0];
            if (req[arb_cand]) begin
                arb_found = 1'b1;
                arb_idx   = arb_cand;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == PTR_W'(i)) begin
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // State register: async clear leaves no pending done/timeout pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ptr_q     <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            data_q    <= '0;
            timeout_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            data_q    <= data_d;
            timeout_q <= timeout_d;
            perr_q    <= perr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        data_d    = data_q;
        done_d    = '0;
        timeout_d = 1'b0;
        perr_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                perr_d = dAck;
                if (arb_found) begin
                    state_d = S_XFER;
                    cnt_d   = '0;
                    gnt_d   = NUM_REQ'(1) << arb_idx;
                    data_d  = sel_data;
                    ptr_d   = (arb_idx == LAST_REQ) ? '0 : arb_idx + PTR_W'(1);
                end
            end
            S_XFER: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (dAck && cnt_q != '0) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    gnt_d   = '0;
                    done_d  = gnt_q;
                end else if (!dAck && cnt_q == CNT_LAST) begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    gnt_d     = '0;
                    timeout_d = 1'b1;
                end else if (dAck) begin
                    // An ack in the very first valid cycle is too early to count.
                    perr_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        dValid    = (state_q == S_XFER);
        busy      = (state_q == S_XFER);
        gnt       = gnt_q;
        data      = data_q;
        done      = done_q;
        timeout   = timeout_q;
        proto_err = perr_q;
    end

endmodule
